// File: rtl/cva6_custom_vec_scratchpad.sv
// Multi-port vector scratchpad: byte-masked write port, NrReadPorts registered
// read ports with write-to-read forwarding, and a hardware clear sequencer.
module cva6_custom_vec_scratchpad #(
  parameter int unsigned NumWords     = 512,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned NrReadPorts  = 2,
  parameter bit          ClearOnReset = 1'b1,
  parameter int unsigned AddrW        = $clog2(NumWords)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_req_i,
  output logic                             busy_o,
  output logic                             clear_done_o,
  input  logic                             we_i,
  input  logic [AddrW-1:0]                 waddr_i,
  input  logic [DataWidth-1:0]             wdata_i,
  input  logic [DataWidth/8-1:0]           wbe_i,
  output logic                             wready_o,
  input  logic [NrReadPorts-1:0]           rreq_i,
  input  logic [NrReadPorts*AddrW-1:0]     raddr_i,
  output logic [NrReadPorts-1:0]           rgnt_o,
  output logic [NrReadPorts-1:0]           rvalid_o,
  output logic [NrReadPorts*DataWidth-1:0] rdata_o,
  output logic [NrReadPorts-1:0]           rerr_o,
  output logic                             werr_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam logic [AddrW-1:0] LastAddr = AddrW'(NumWords - 1);

  typedef enum logic {IDLE, CLEAR} state_e;
  localparam state_e ResetState = ClearOnReset ? CLEAR : IDLE;

  function automatic logic in_range(input logic [AddrW-1:0] a);
    return 32'(a) < NumWords;
  endfunction

  function automatic logic [DataWidth-1:0] merge_bytes(
    input logic [DataWidth-1:0] old_word,
    input logic [DataWidth-1:0] new_word,
    input logic [NumBytes-1:0]  be
  );
    logic [DataWidth-1:0] res;
    res = old_word;
    for (int b = 0; b < int'(NumBytes); b++) begin
      if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

  logic [DataWidth-1:0] mem [NumWords];

  state_e               state_reg, state_next;
  logic [AddrW-1:0]     cnt_reg, cnt_next;
  logic                 clear_last;
  logic                 clear_done_reg;
  logic                 werr_reg;
  logic                 port_open;
  logic                 wr_fire;
  logic                 wr_in_range;
  logic [DataWidth-1:0] wr_word;

  logic [NrReadPorts-1:0] rvalid_reg;
  logic [NrReadPorts-1:0] rerr_reg;
  logic [DataWidth-1:0]   rdata_reg   [NrReadPorts];
  logic [AddrW-1:0]       raddr       [NrReadPorts];
  logic                   rd_in_range [NrReadPorts];
  logic [DataWidth-1:0]   rd_word     [NrReadPorts];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clear_last = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clear_req_i) state_next = CLEAR;
      end
      CLEAR: begin
        if (cnt_reg == LastAddr) begin
          clear_last = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ResetState;
    endcase
  end

  // A clear request in the same cycle takes priority over every port.
  assign port_open   = (state_reg == IDLE) && !clear_req_i;
  assign wready_o    = port_open;
  assign wr_fire     = we_i && port_open;
  assign wr_in_range = wr_fire && in_range(waddr_i);
  assign wr_word     = merge_bytes(mem[waddr_i], wdata_i, wbe_i);

  assign busy_o       = (state_reg == CLEAR);
  assign clear_done_o = clear_done_reg;
  assign werr_o       = werr_reg;
  assign rvalid_o     = rvalid_reg;
  assign rerr_o       = rerr_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= ResetState;
      cnt_reg        <= '0;
      clear_done_reg <= 1'b0;
      werr_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      clear_done_reg <= clear_last;
      werr_reg       <= wr_fire && !in_range(waddr_i);
    end
  end

  // Storage has no reset; the clear sequencer and the write port share one write path.
  always_ff @(posedge clk_i) begin
    if (state_reg == CLEAR) begin
      mem[cnt_reg] <= '0;
    end else if (wr_in_range) begin
      mem[waddr_i] <= wr_word;
    end
  end

  for (genvar gi = 0; gi < int'(NrReadPorts); gi++) begin : g_rport
    assign raddr[gi]       = raddr_i[gi*AddrW +: AddrW];
    assign rgnt_o[gi]      = rreq_i[gi] && port_open;
    assign rd_in_range[gi] = in_range(raddr[gi]);
    // Same-cycle write to the same word is forwarded as the merged post-write value.
    assign rd_word[gi]     = (wr_in_range && (waddr_i == raddr[gi])) ? wr_word : mem[raddr[gi]];
    assign rdata_o[gi*DataWidth +: DataWidth] = rdata_reg[gi];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_reg <= '0;
      rerr_reg   <= '0;
      for (int p = 0; p < int'(NrReadPorts); p++) rdata_reg[p] <= '0;
    end else begin
      for (int p = 0; p < int'(NrReadPorts); p++) begin
        rvalid_reg[p] <= rgnt_o[p];
        rerr_reg[p]   <= rgnt_o[p] && !rd_in_range[p];
        if (rgnt_o[p]) rdata_reg[p] <= rd_in_range[p] ? rd_word[p] : '0;
      end
    end
  end

endmodule

// File: tb/tb_cva6_custom_vec_scratchpad.sv
// Self-checking bench: directed vector table, clear/reset corner sequences and
// randomized traffic checked against a simple word-array reference model.
module tb_cva6_custom_vec_scratchpad;

  localparam int NW = 300;
  localparam int AW = 9;
  localparam int DW = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_req_i;
  logic          busy_o, clear_done_o;
  logic          we_i;
  logic [AW-1:0] waddr_i;
  logic [DW-1:0] wdata_i;
  logic [7:0]    wbe_i;
  logic          wready_o;
  logic [1:0]    rreq_i;
  logic [2*AW-1:0] raddr_i;
  logic [1:0]    rgnt_o, rvalid_o, rerr_o;
  logic [2*DW-1:0] rdata_o;
  logic          werr_o;

  cva6_custom_vec_scratchpad #(
    .NumWords(NW), .DataWidth(DW), .NrReadPorts(2), .ClearOnReset(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_req_i(clear_req_i),
    .busy_o(busy_o), .clear_done_o(clear_done_o),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .wbe_i(wbe_i),
    .wready_o(wready_o), .rreq_i(rreq_i), .raddr_i(raddr_i),
    .rgnt_o(rgnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .rerr_o(rerr_o), .werr_o(werr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [7:0]    wbe;
    logic [1:0]    rreq;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] ed0, ed1;
    logic [1:0]    erer;
    logic          ewerr;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] mdl [NW];
  vec_t tbl [10];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic we, input int wa, input logic [DW-1:0] wd,
                               input logic [7:0] be, input logic [1:0] rreq,
                               input int ra0, input int ra1,
                               input logic [DW-1:0] ed0, input logic [DW-1:0] ed1,
                               input logic [1:0] erer, input logic ewerr);
    vec_t v;
    v.we = we; v.waddr = AW'(wa); v.wdata = wd; v.wbe = be; v.rreq = rreq;
    v.ra0 = AW'(ra0); v.ra1 = AW'(ra1); v.ed0 = ed0; v.ed1 = ed1;
    v.erer = erer; v.ewerr = ewerr;
    return v;
  endfunction

  function automatic logic [DW-1:0] mrg(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                        input logic [7:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NW; i++) mdl[i] = '0;
  endtask

  task automatic model_write(input vec_t v);
    if (v.we && int'(v.waddr) < NW) mdl[v.waddr] = mrg(mdl[v.waddr], v.wdata, v.wbe);
  endtask

  // Called at posedge+1 with the DUT idle; returns at the next posedge+1.
  task automatic apply(input vec_t v, input string tag);
    we_i = v.we; waddr_i = v.waddr; wdata_i = v.wdata; wbe_i = v.wbe;
    rreq_i = v.rreq; raddr_i = {v.ra1, v.ra0};
    #1;
    chk({tag, " wready"}, 64'(wready_o), 64'd1);
    chk({tag, " rgnt"}, 64'(rgnt_o), 64'(v.rreq));
    @(posedge clk_i); #1;
    we_i = 1'b0; rreq_i = 2'b00;
    chk({tag, " rvalid"}, 64'(rvalid_o), 64'(v.rreq));
    chk({tag, " rerr"}, 64'(rerr_o), 64'(v.erer));
    chk({tag, " werr"}, 64'(werr_o), 64'(v.ewerr));
    if (v.rreq[0]) chk({tag, " rdata0"}, rdata_o[DW-1:0], v.ed0);
    if (v.rreq[1]) chk({tag, " rdata1"}, rdata_o[2*DW-1:DW], v.ed1);
    $display("txn %s we=%0d wa=%0d be=%h rreq=%b ra0=%0d ra1=%0d rd0=%h rd1=%h rerr=%b werr=%0d",
             tag, v.we, v.waddr, v.wbe, v.rreq, v.ra0, v.ra1,
             rdata_o[DW-1:0], rdata_o[2*DW-1:DW], rerr_o, werr_o);
  endtask

  // Expectations come from the model: write applied first, then reads see the result.
  task automatic model_step(input logic we, input int wa, input logic [DW-1:0] wd,
                            input logic [7:0] be, input logic [1:0] rreq,
                            input int ra0, input int ra1, input string tag);
    vec_t v;
    v = mkv(we, wa, wd, be, rreq, ra0, ra1, '0, '0, 2'b00, 1'b0);
    model_write(v);
    if (ra0 < NW) v.ed0 = mdl[ra0];
    if (ra1 < NW) v.ed1 = mdl[ra1];
    v.erer  = {rreq[1] && ra1 >= NW, rreq[0] && ra0 >= NW};
    v.ewerr = we && wa >= NW;
    apply(v, tag);
  endtask

  task automatic measure_clear(input string tag, input int reassert_at);
    int busy_n;
    int done_n;
    busy_n = 0;
    done_n = 0;
    for (int c = 0; c < 2000 && busy_o; c++) begin
      busy_n++;
      clear_req_i = (c == reassert_at);
      @(posedge clk_i); #1;
      clear_req_i = 1'b0;
      if (clear_done_o) done_n++;
    end
    chk({tag, " busy cycles"}, 64'(busy_n), 64'(NW));
    chk({tag, " done pulses"}, 64'(done_n), 64'd1);
    chk({tag, " done first idle"}, 64'(clear_done_o), 64'd1);
    chk({tag, " wready after"}, 64'(wready_o), 64'd1);
    @(posedge clk_i); #1;
    chk({tag, " done drops"}, 64'(clear_done_o), 64'd0);
    model_clear();
  endtask

  function automatic int rnd_addr();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return int'($urandom_range(NW, 511));
    if (sel < 5)  return int'($urandom_range(0, 15));
    return int'($urandom_range(0, NW - 1));
  endfunction

  initial begin
    tbl[0] = mkv(1, 7,   64'h1122334455667788, 8'hFF, 2'b00, 0,   0,   '0, '0, 2'b00, 0);
    tbl[1] = mkv(1, 7,   64'hAAAAAAAAAAAAAAAA, 8'h0F, 2'b00, 0,   0,   '0, '0, 2'b00, 0);
    tbl[2] = mkv(0, 0,   '0,                   8'h00, 2'b11, 7,   3,   64'h11223344AAAAAAAA, '0, 2'b00, 0);
    tbl[3] = mkv(1, 3,   64'hDEADBEEF00000001, 8'hFF, 2'b11, 3,   3,   64'hDEADBEEF00000001, 64'hDEADBEEF00000001, 2'b00, 0);
    tbl[4] = mkv(0, 0,   '0,                   8'h00, 2'b11, 310, 299, '0, '0, 2'b01, 0);
    tbl[5] = mkv(1, 400, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'b00, 0,   0,   '0, '0, 2'b00, 1);
    tbl[6] = mkv(0, 0,   '0,                   8'h00, 2'b11, 144, 100, '0, '0, 2'b00, 0);
    tbl[7] = mkv(1, 7,   64'hFFFFFFFFFFFFFFFF, 8'h00, 2'b01, 7,   0,   64'h11223344AAAAAAAA, '0, 2'b00, 0);
    tbl[8] = mkv(1, 299, 64'h0123456789ABCDEF, 8'hF0, 2'b11, 7,   299, 64'h11223344AAAAAAAA, 64'h0123456700000000, 2'b00, 0);
    tbl[9] = mkv(0, 0,   '0,                   8'h00, 2'b11, 3,   511, 64'hDEADBEEF00000001, '0, 2'b10, 0);

    // Reset values, with requests driven to show they are gated off.
    rst_ni = 1'b0; clear_req_i = 1'b0; we_i = 1'b1; waddr_i = '0; wdata_i = '1;
    wbe_i = 8'hFF; rreq_i = 2'b11; raddr_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset busy", 64'(busy_o), 64'd1);
    chk("reset clear_done", 64'(clear_done_o), 64'd0);
    chk("reset wready", 64'(wready_o), 64'd0);
    chk("reset rgnt", 64'(rgnt_o), 64'd0);
    chk("reset rvalid", 64'(rvalid_o), 64'd0);
    chk("reset rdata", rdata_o[DW-1:0] | rdata_o[2*DW-1:DW], 64'd0);
    chk("reset rerr", 64'(rerr_o), 64'd0);
    chk("reset werr", 64'(werr_o), 64'd0);
    we_i = 1'b0; rreq_i = 2'b00;
    rst_ni = 1'b1;
    measure_clear("reset clear", -1);
    model_step(0, 0, '0, 8'h00, 2'b11, 0, 0, "post-reset rd0");
    model_step(0, 0, '0, 8'h00, 2'b11, 255, 255, "post-reset rd255");
    model_step(0, 0, '0, 8'h00, 2'b11, NW - 1, NW - 1, "post-reset rdlast");

    foreach (tbl[i]) begin
      model_write(tbl[i]);
      apply(tbl[i], $sformatf("table%0d", i));
    end

    // Clear request collides with a write and reads; later re-requested mid-clear.
    clear_req_i = 1'b1; we_i = 1'b1; waddr_i = 9'd5; wdata_i = 64'h5555; wbe_i = 8'hFF;
    rreq_i = 2'b11; raddr_i = {9'd7, 9'd3};
    #1;
    chk("collide wready", 64'(wready_o), 64'd0);
    chk("collide rgnt", 64'(rgnt_o), 64'd0);
    @(posedge clk_i); #1;
    clear_req_i = 1'b0; we_i = 1'b0; rreq_i = 2'b00;
    chk("collide rvalid", 64'(rvalid_o), 64'd0);
    chk("collide werr", 64'(werr_o), 64'd0);
    measure_clear("req clear", 100);
    model_step(0, 0, '0, 8'h00, 2'b11, 7, 3, "after clear");
    model_step(0, 0, '0, 8'h00, 2'b11, 5, NW - 1, "after clear b");

    for (int i = 0; i < 400; i++) begin
      model_step(1'($urandom_range(0, 1)), rnd_addr(), {$urandom, $urandom},
                 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                 rnd_addr(), rnd_addr(), $sformatf("rand%0d", i));
    end

    // Reset pulled in the middle of a clear: sequence restarts from word 0.
    clear_req_i = 1'b1;
    @(posedge clk_i); #1;
    clear_req_i = 1'b0;
    repeat (150) @(posedge clk_i);
    #1;
    chk("mid-clear busy before rst", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid-clear rst busy", 64'(busy_o), 64'd1);
    chk("mid-clear rst done", 64'(clear_done_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    measure_clear("rst mid-clear", -1);
    for (int a = 0; a < 16; a += 5) model_step(0, 0, '0, 8'h00, 2'b11, a, a + 1, "post rst rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
